// File: rtl/move_cmd_if.sv
// Handshake bundle around move_cmd_arbiter: remote/tour requesters, cmd_proc link and UART response path.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface move_cmd_if;
  logic [15:0] rmt_cmd;
  logic        rmt_cmd_rdy;
  logic        clr_rmt_cmd_rdy;
  logic [15:0] tour_cmd;
  logic        tour_cmd_rdy;
  logic        clr_tour_cmd_rdy;
  logic        start_tour;
  logic [7:0]  tour_xy;
  logic        tour_active;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        timeout_err;

  modport master (
    input  rmt_cmd, rmt_cmd_rdy, tour_cmd, tour_cmd_rdy, clr_cmd_rdy, send_resp, tx_done,
    output clr_rmt_cmd_rdy, clr_tour_cmd_rdy, start_tour, tour_xy, tour_active,
           cmd, cmd_rdy, resp, trmt, timeout_err
  );

  modport slave (
    output rmt_cmd, rmt_cmd_rdy, tour_cmd, tour_cmd_rdy, clr_cmd_rdy, send_resp, tx_done,
    input  clr_rmt_cmd_rdy, clr_tour_cmd_rdy, start_tour, tour_xy, tour_active,
           cmd, cmd_rdy, resp, trmt, timeout_err
  );
endinterface

// File: rtl/move_cmd_arbiter.sv
// Shares cmd_proc between the remote UART path and the tour move generator, and picks UART response bytes.
// Optional command watchdog enabled with `define CMD_TIMEOUT_EN.
module move_cmd_arbiter #(
  parameter int unsigned NUM_TOUR_CMDS = 48
`ifdef CMD_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  move_cmd_if.master bus
);

  localparam int unsigned       CNT_W         = $clog2(NUM_TOUR_CMDS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX      = CNT_W'(NUM_TOUR_CMDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX       = CNT_W'(NUM_TOUR_CMDS);
  localparam logic [3:0]        OP_START_TOUR = 4'h4;
  localparam logic [7:0]        RESP_DONE     = 8'hA5;
  localparam logic [7:0]        RESP_MOVE     = 8'h5A;
  localparam logic [7:0]        RESP_ABORT    = 8'hEE;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, WAIT_TX} state_e;
  typedef enum logic {OWN_RMT, OWN_TOUR} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [7:0]       resp_q, resp_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       tour_xy_q, tour_xy_d;
  logic             tour_active_q, tour_active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             end_tour_q, end_tour_d;
  logic             timeout_err_q, timeout_err_d;
  logic             clr_rmt_c, clr_tour_c, start_tour_c;
  logic             done_c, abort_c, timeout_hit_c;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;

  // Watchdog runs only while a command is outstanding; it sits at zero otherwise.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ISSUE || state_q == BUSY) to_cnt_d = to_cnt_q + 24'd1;
  end

  assign timeout_hit_c = (state_q == ISSUE || state_q == BUSY) &&
                         (to_cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit_c = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cmd_d         = cmd_q;
    cmd_rdy_d     = cmd_rdy_q;
    resp_d        = resp_q;
    trmt_d        = 1'b0;
    tour_xy_d     = tour_xy_q;
    tour_active_d = tour_active_q;
    cnt_d         = cnt_q;
    end_tour_d    = end_tour_q;
    timeout_err_d = timeout_err_q;
    clr_rmt_c     = 1'b0;
    clr_tour_c    = 1'b0;
    start_tour_c  = 1'b0;
    done_c        = 1'b0;
    abort_c       = 1'b0;

    unique case (state_q)
      // Tour owns cmd_proc while active; remote requests wait until it ends.
      IDLE: begin
        if (tour_active_q && bus.tour_cmd_rdy) begin
          cmd_d         = bus.tour_cmd;
          owner_d       = OWN_TOUR;
          clr_tour_c    = 1'b1;
          cmd_rdy_d     = 1'b1;
          timeout_err_d = 1'b0;
          state_d       = ISSUE;
        end else if (!tour_active_q && bus.rmt_cmd_rdy &&
                     bus.rmt_cmd[15:12] == OP_START_TOUR) begin
          clr_rmt_c     = 1'b1;
          start_tour_c  = 1'b1;
          tour_xy_d     = bus.rmt_cmd[7:0];
          tour_active_d = 1'b1;
          cnt_d         = '0;
        end else if (!tour_active_q && bus.rmt_cmd_rdy) begin
          cmd_d         = bus.rmt_cmd;
          owner_d       = OWN_RMT;
          clr_rmt_c     = 1'b1;
          cmd_rdy_d     = 1'b1;
          timeout_err_d = 1'b0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.clr_cmd_rdy && bus.send_resp) begin
          done_c = 1'b1;
        end else if (timeout_hit_c) begin
          abort_c = 1'b1;
        end else if (bus.clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.send_resp)      done_c  = 1'b1;
        else if (timeout_hit_c) abort_c = 1'b1;
      end
      RESP: begin
        if (owner_q == OWN_TOUR && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (end_tour_q) tour_active_d = 1'b0;
          end_tour_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response byte is chosen as RESP is entered, using the pre-increment move count.
    if (done_c || abort_c) begin
      state_d   = RESP;
      trmt_d    = 1'b1;
      cmd_rdy_d = 1'b0;
    end
    if (abort_c) begin
      resp_d        = RESP_ABORT;
      timeout_err_d = 1'b1;
      end_tour_d    = 1'b1;
    end else if (done_c) begin
      if (owner_q == OWN_TOUR && cnt_q == LAST_IDX) begin
        resp_d     = RESP_DONE;
        end_tour_d = 1'b1;
      end else if (owner_q == OWN_TOUR) begin
        resp_d     = RESP_MOVE;
        end_tour_d = 1'b0;
      end else begin
        resp_d     = RESP_DONE;
        end_tour_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_RMT;
      cmd_q         <= '0;
      cmd_rdy_q     <= 1'b0;
      resp_q        <= '0;
      trmt_q        <= 1'b0;
      tour_xy_q     <= '0;
      tour_active_q <= 1'b0;
      cnt_q         <= '0;
      end_tour_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
      resp_q        <= resp_d;
      trmt_q        <= trmt_d;
      tour_xy_q     <= tour_xy_d;
      tour_active_q <= tour_active_d;
      cnt_q         <= cnt_d;
      end_tour_q    <= end_tour_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Consume pulses are same-cycle decodes; held low while reset is asserted.
  assign bus.clr_rmt_cmd_rdy  = clr_rmt_c & ~rst;
  assign bus.clr_tour_cmd_rdy = clr_tour_c & ~rst;
  assign bus.start_tour       = start_tour_c & ~rst;
  assign bus.tour_xy          = tour_xy_q;
  assign bus.tour_active      = tour_active_q;
  assign bus.cmd              = cmd_q;
  assign bus.cmd_rdy          = cmd_rdy_q;
  assign bus.resp             = resp_q;
  assign bus.trmt             = trmt_q;
  assign bus.timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_move_cmd_arbiter.sv
// Scoreboard bench for move_cmd_arbiter with a four-move tour; watchdog scenario runs when CMD_TIMEOUT_EN is defined.
module tb_move_cmd_arbiter;
  localparam int unsigned NCMD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_cmd_if bus();

  move_cmd_arbiter #(
    .NUM_TOUR_CMDS(NCMD)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(24'd100)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cmd_proc and UART responder: accept the pending command, finish it, check the response strobe.
  task automatic serve(input bit same_cycle);
    logic [15:0] ec;
    logic [7:0]  er;
    int n;
    n = 0;
    while (bus.cmd_rdy !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL serve_cmd_rdy_wait got %b want 1", bus.cmd_rdy); end
    ec = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 16'hxxxx;
    er = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 8'hxx;
    checks++;
    if (bus.cmd !== ec) begin errors++; $display("FAIL serve_cmd got %h want %h", bus.cmd, ec); end
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp   = same_cycle;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    if (!same_cycle) begin
      checks++;
      if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL serve_busy_cmd_rdy got %b want 0", bus.cmd_rdy); end
      tick();
      tick();
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
    end
    checks++;
    if (bus.trmt !== 1'b1 || bus.resp !== er) begin
      errors++; $display("FAIL serve_resp got trmt=%b resp=%h want trmt=1 resp=%h", bus.trmt, bus.resp, er);
    end
    tick();
    checks++;
    if (bus.trmt !== 1'b0 || bus.resp !== er) begin
      errors++; $display("FAIL serve_resp_hold got trmt=%b resp=%h want trmt=0 resp=%h", bus.trmt, bus.resp, er);
    end
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rmt_cmd_rdy = 1'b1;
    #1;
    checks++;
    if ({bus.cmd, bus.cmd_rdy, bus.resp, bus.trmt, bus.tour_xy, bus.tour_active, bus.timeout_err,
         bus.clr_rmt_cmd_rdy, bus.start_tour} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs got cmd=%h rdy=%b resp=%h trmt=%b xy=%h act=%b clr=%b want all 0",
                         bus.cmd, bus.cmd_rdy, bus.resp, bus.trmt, bus.tour_xy, bus.tour_active, bus.clr_rmt_cmd_rdy);
    end
    bus.rmt_cmd_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_remote();
    logic [15:0] rc [2];
    rc[0] = 16'h0000;
    rc[1] = 16'h5123;
    for (int i = 0; i < 2; i++) begin
      bus.rmt_cmd = rc[i];
      bus.rmt_cmd_rdy = 1'b1;
      exp_cmd_q.push_back(rc[i]);
      exp_resp_q.push_back(8'hA5);
      #1;
      checks++;
      if (bus.clr_rmt_cmd_rdy !== 1'b1 || bus.start_tour !== 1'b0) begin
        errors++; $display("FAIL remote_grant got clr=%b start=%b want clr=1 start=0", bus.clr_rmt_cmd_rdy, bus.start_tour);
      end
      tick();
      bus.rmt_cmd_rdy = 1'b0;
      checks++;
      if (bus.cmd_rdy !== 1'b1 || bus.clr_rmt_cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL remote_latency got cmd_rdy=%b clr=%b want cmd_rdy=1 clr=0", bus.cmd_rdy, bus.clr_rmt_cmd_rdy);
      end
      serve(i == 1);
    end
  endtask

  task automatic test_start_tour();
    bus.rmt_cmd = 16'h4022;
    bus.rmt_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_rmt_cmd_rdy !== 1'b1 || bus.start_tour !== 1'b1) begin
      errors++; $display("FAIL start_pulse got clr=%b start=%b want 1 1", bus.clr_rmt_cmd_rdy, bus.start_tour);
    end
    tick();
    bus.rmt_cmd_rdy = 1'b0;
    checks++;
    if (bus.tour_xy !== 8'h22 || bus.tour_active !== 1'b1 || bus.start_tour !== 1'b0 || bus.trmt !== 1'b0) begin
      errors++; $display("FAIL start_state got xy=%h act=%b start=%b trmt=%b want 22 1 0 0",
                         bus.tour_xy, bus.tour_active, bus.start_tour, bus.trmt);
    end
    tick();
    checks++;
    if (bus.trmt !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL start_no_resp got trmt=%b cmd_rdy=%b want 0 0", bus.trmt, bus.cmd_rdy);
    end
  endtask

  task automatic test_tour_contention();
    logic [15:0] tc [4];
    tc[0] = 16'h2123; tc[1] = 16'h3456; tc[2] = 16'h2789; tc[3] = 16'h3ABC;
    bus.rmt_cmd = 16'h2000;
    bus.rmt_cmd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (bus.clr_rmt_cmd_rdy !== 1'b0) begin errors++; $display("FAIL tour_rmt_blocked got %b want 0", bus.clr_rmt_cmd_rdy); end
      bus.tour_cmd = tc[i];
      bus.tour_cmd_rdy = 1'b1;
      exp_cmd_q.push_back(tc[i]);
      exp_resp_q.push_back((i == 3) ? 8'hA5 : 8'h5A);
      #1;
      checks++;
      if (bus.clr_tour_cmd_rdy !== 1'b1 || bus.clr_rmt_cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL tour_grant got clr_tour=%b clr_rmt=%b want 1 0", bus.clr_tour_cmd_rdy, bus.clr_rmt_cmd_rdy);
      end
      tick();
      bus.tour_cmd_rdy = 1'b0;
      serve(i == 1);
      checks++;
      if (bus.tour_active !== ((i == 3) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL tour_active_%0d got %b want %b", i, bus.tour_active, (i != 3));
      end
    end
    checks++;
    if (bus.clr_rmt_cmd_rdy !== 1'b1) begin errors++; $display("FAIL tour_rmt_after got %b want 1", bus.clr_rmt_cmd_rdy); end
    exp_cmd_q.push_back(16'h2000);
    exp_resp_q.push_back(8'hA5);
    tick();
    bus.rmt_cmd_rdy = 1'b0;
    serve(1'b0);
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.rmt_cmd = 16'h4011;
    bus.rmt_cmd_rdy = 1'b1;
    tick();
    bus.rmt_cmd_rdy = 1'b0;
    bus.tour_cmd = 16'h2AAA;
    bus.tour_cmd_rdy = 1'b1;
    tick();
    bus.tour_cmd_rdy = 1'b0;
    bus.clr_cmd_rdy = 1'b1;
    n = 0;
    while (bus.trmt !== 1'b1 && n < 300) begin tick(); bus.clr_cmd_rdy = 1'b0; n++; end
    checks++;
    if (n != 100 || bus.resp !== 8'hEE || bus.timeout_err !== 1'b1 || bus.tour_active !== 1'b1) begin
      errors++; $display("FAIL timeout_abort got cycles=%0d resp=%h err=%b act=%b want 100 EE 1 1",
                         n, bus.resp, bus.timeout_err, bus.tour_active);
    end
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++;
    if (bus.tour_active !== 1'b0 || bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_end got act=%b err=%b want 0 1", bus.tour_active, bus.timeout_err);
    end
    bus.rmt_cmd = 16'h0000;
    bus.rmt_cmd_rdy = 1'b1;
    exp_cmd_q.push_back(16'h0000);
    exp_resp_q.push_back(8'hA5);
    tick();
    bus.rmt_cmd_rdy = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", bus.timeout_err); end
    serve(1'b0);
  endtask
`endif

  task automatic test_reset_mid_busy();
    bus.rmt_cmd = 16'h4035;
    bus.rmt_cmd_rdy = 1'b1;
    tick();
    bus.rmt_cmd_rdy = 1'b0;
    bus.tour_cmd = 16'h2222;
    bus.tour_cmd_rdy = 1'b1;
    tick();
    bus.tour_cmd_rdy = 1'b0;
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd, bus.cmd_rdy, bus.resp, bus.trmt, bus.tour_xy, bus.tour_active} !== 34'h0) begin
      errors++; $display("FAIL reset_async got cmd=%h rdy=%b resp=%h trmt=%b xy=%h act=%b want all 0",
                         bus.cmd, bus.cmd_rdy, bus.resp, bus.trmt, bus.tour_xy, bus.tour_active);
    end
    tick();
    #2;
    rst = 1'b0;
    tick();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.trmt !== 1'b0 || bus.cmd_rdy !== 1'b0 || bus.tour_active !== 1'b0) begin
        errors++; $display("FAIL reset_idle got trmt=%b cmd_rdy=%b act=%b want 0 0 0", bus.trmt, bus.cmd_rdy, bus.tour_active);
      end
      tick();
    end
  endtask

  initial begin
    bus.rmt_cmd = '0;
    bus.rmt_cmd_rdy = 1'b0;
    bus.tour_cmd = '0;
    bus.tour_cmd_rdy = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    bus.tx_done = 1'b0;
    test_reset();
    test_remote();
    test_start_tour();
    test_tour_contention();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    checks++;
    if (exp_cmd_q.size() != 0 || exp_resp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got cmd=%0d resp=%0d want 0 0", exp_cmd_q.size(), exp_resp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timed out");
  end
endmodule

// File: doc/move_cmd_arbiter.md
Name: move_cmd_arbiter

Overview:
- Sole source of commands for cmd_proc.
- Shares cmd_proc between two requesters:
  - the remote UART command path;
  - the tour move generator, which emits one L-move as two commands.
- Sequences the start-of-tour handoff and counts tour commands.
- Selects each response byte sent back over the UART: 0xA5 on completion, 0x5A on intermediate tour moves.

Parameters:
NUM_TOUR_CMDS, 48, number of move commands in a full tour; the last one gets 0xA5.
TIMEOUT_CYCLES, 24'd10_000_000, cycles allowed in ISSUE+BUSY before abort. Used only with CMD_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rmt_cmd  in  16  command from UART wrapper
rmt_cmd_rdy  in  1  remote command valid (held until cleared)
clr_rmt_cmd_rdy  out  1  one-cycle pulse: remote command consumed
tour_cmd  in  16  command from tour move generator
tour_cmd_rdy  in  1  tour command valid (held until cleared)
clr_tour_cmd_rdy  out  1  one-cycle pulse: tour command consumed
start_tour  out  1  one-cycle pulse to tour logic
tour_xy  out  8  registered start square, {x[3:0],y[3:0]} = rmt_cmd[7:0]
tour_active  out  1  high from start_tour until the final tour response is sent
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc accepted command
send_resp  in  1  cmd_proc finished command (one-cycle pulse)
resp  out  8  response byte to UART transmitter
trmt  out  1  one-cycle transmit strobe
tx_done  in  1  UART transmit complete
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: cmd=16'h0, resp=8'h0, tour_xy=8'h0.
  - Move counter = 0.
- Reset mid-operation: the command in flight is dropped. A requester already cleared is not re-served.
- States: IDLE, ISSUE, BUSY, RESP, WAIT_TX.
- IDLE arbitration, evaluated each cycle:
  - If tour_active && tour_cmd_rdy:
    - Grant tour: cmd<=tour_cmd, owner<=TOUR, clr_tour_cmd_rdy pulses this cycle, ->ISSUE.
  - Else if !tour_active && rmt_cmd_rdy && rmt_cmd[15:12]==4'h4 (start tour):
    - clr_rmt_cmd_rdy and start_tour pulse this cycle.
    - tour_xy<=rmt_cmd[7:0], tour_active<=1, counter<=0.
    - Stay IDLE. No response is sent.
  - Else if !tour_active && rmt_cmd_rdy:
    - Grant remote: cmd<=rmt_cmd, owner<=RMT, clr_rmt_cmd_rdy pulses, ->ISSUE.
  - While tour_active, remote requests are never cleared; they stay pending until tour_active falls.
- ISSUE:
  - cmd_rdy=1 until clr_cmd_rdy is sampled high; cmd stays stable.
  - On clr_cmd_rdy: ->BUSY. cmd_rdy=0 from the next cycle.
  - If send_resp is high in the same cycle as clr_cmd_rdy: ->RESP directly.
- BUSY: wait for send_resp, then ->RESP.
- RESP (one cycle): trmt=1, resp registered.
  - owner RMT: resp=8'hA5.
  - owner TOUR with counter==NUM_TOUR_CMDS-1: resp=8'hA5; tour_active is cleared on tx_done.
  - owner TOUR otherwise: resp=8'h5A.
  - owner TOUR: counter increments.
  - ->WAIT_TX.
- WAIT_TX: on tx_done ->IDLE. resp is held until then.
- Counter: width $clog2(NUM_TOUR_CMDS+1); saturates, never wraps.
- Latency: grant to cmd_rdy = 1 cycle; send_resp to trmt = 1 cycle.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to ISSUE and counts in ISSUE/BUSY.
  - On reaching TIMEOUT_CYCLES without send_resp: cmd_rdy<=0, ->RESP with resp=8'hEE, timeout_err<=1.
  - tour_active clears on the following tx_done.
  - timeout_err clears on the next grant.
- Undefined: ISSUE/BUSY wait indefinitely; timeout_err is tied 0.

Test Plan:
- Reset: assert rst mid-BUSY -> outputs 0 asynchronously; after release, state IDLE with cmd_rdy=0 and trmt=0.
- Remote calibrate:
  - Stimulus: rmt_cmd=16'h0000, rmt_cmd_rdy=1.
  - Response: clr_rmt_cmd_rdy pulses; next cycle cmd_rdy=1, cmd=16'h0000.
  - Stimulus: clr_cmd_rdy, then send_resp.
  - Response: trmt pulses with resp=8'hA5; IDLE after tx_done.
- Start tour: rmt_cmd=16'h4022 -> start_tour pulses, tour_xy=8'h22, tour_active=1, no trmt.
- Tour with NUM_TOUR_CMDS=4:
  - Stimulus: four tour commands 16'h2xxx/16'h3xxx, each completed.
  - Response: resp sequence 5A,5A,5A,A5; tour_active falls on the 4th tx_done.
- Contention:
  - Stimulus: during the tour, rmt_cmd_rdy=1 with rmt_cmd=16'h2000, alongside tour_cmd_rdy.
  - Response: only tour commands are granted, clr_rmt_cmd_rdy stays 0; remote is granted on the first IDLE cycle after tour_active falls.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100:
  - Stimulus: grant a tour command; never assert send_resp.
  - Response: after 100 cycles, trmt with resp=8'hEE, timeout_err=1; tour_active falls after tx_done.
